vend_credit_ctrl: RTL
=====================

Name: vend_credit_ctrl

Overview:
Upstream control stage for the vending machine seven-segment display block. Conditions the raw coin inputs (m1 = 1-unit coin, m5 = 5-unit coin), the item buttons (i1..i3) and cancel. Accumulates credit and runs the purchase FSM. Emits a one-cycle vend strobe with item id, change/refund amount and current credit, which the display stage and dispense hardware consume.

Parameters:
PRICE1, 1, price of item 1 in coin units
PRICE2, 2, price of item 2
PRICE3, 3, price of item 3
MAX_CREDIT, 15, credit ceiling; must be less than 2**CW
CW, 4, width of credit and change
TIMEOUT, 50000000, idle cycles in COLLECT before auto-refund

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
m1  in  1  1-unit coin sensor, asynchronous level
m5  in  1  5-unit coin sensor, asynchronous level
i1  in  1  item 1 select button, asynchronous level
i2  in  1  item 2 select button, asynchronous level
i3  in  1  item 3 select button, asynchronous level
cancel  in  1  refund request, asynchronous level
credit  out  CW  current accumulated credit
vend  out  1  one-cycle dispense strobe
item  out  2  item id valid with vend (1..3), 0 otherwise
change  out  CW  change/refund amount, valid with change_valid
change_valid  out  1  one-cycle change/refund strobe
reject  out  1  one-cycle pulse: coin not accepted, mechanically returned
busy  out  1  high in VEND, CHANGE and REFUND

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous, active-high. While rst=1 at an edge: state=IDLE; credit, change, item, timeout counter all 0; vend, change_valid, reject, busy all 0; synchronizer and edge registers 0.
- Input conditioning: each of m1, m5, i1, i2, i3, cancel passes through a 2-FF synchronizer and a rising-edge detector (previous-value register).
- Latency: an input sampled high first at edge k causes its effect (credit/state/output change) at edge k+2.
- A level held high counts once. An input held high across reset release counts as one edge.
- States:
  - IDLE: credit=0.
  - COLLECT: credit>0.
  - VEND: 1 cycle.
  - CHANGE: 1 cycle.
  - REFUND: 1 cycle.
- Coin acceptance (IDLE/COLLECT only):
  - credit += 1 or 5.
  - If the new value would exceed MAX_CREDIT, the coin is rejected: reject=1 for 1 cycle, credit unchanged.
  - m1 and m5 edges in the same cycle: m5 is processed, m1 is rejected.
  - Any accepted coin moves to COLLECT and clears the timeout counter.
- Selection (COLLECT):
  - On a select edge, priority is i1 > i2 > i3; lower-priority edges in the same cycle are dropped.
  - If credit >= price: go to VEND. Credit is reduced by the price at that edge.
  - If credit < price: the edge is ignored; no output, state unchanged.
  - Select edges in IDLE are ignored.
- Coin and select in the same cycle (COLLECT): the selection wins and is evaluated on the pre-coin credit. The coin is rejected.
- VEND: vend=1 and item=id for exactly 1 cycle. Next state: CHANGE if remaining credit > 0, else IDLE.
- CHANGE: change=credit and change_valid=1 for 1 cycle. At that edge credit goes to 0; next state IDLE. change returns to 0 afterwards.
- Cancel edge in COLLECT goes to REFUND. REFUND behaves like CHANGE: change=credit, change_valid=1, credit to 0, then IDLE. Cancel in IDLE is ignored.
- Priority in COLLECT: cancel > select > timeout.
- Timeout: the counter increments every cycle in COLLECT. On reaching TIMEOUT-1 the block enters REFUND.
- Any coin, select or cancel edge while busy=1: coins are rejected (reject pulse); selects and cancels are dropped.
- rst asserted mid-transaction (any state): credit is discarded without a change_valid strobe; all outputs are at reset values at the next edge.
- Arithmetic: unsigned, CW bits. Credit never exceeds MAX_CREDIT and never underflows.

Test Plan:
- Reset, then m1 pulse -> credit=1 exactly 2 edges after first sample. Then i1 -> vend=1, item=1 for 1 cycle, credit=0, no change_valid, back to IDLE.
- m5, then i2 -> vend with item=2, then next cycle change_valid=1, change=3, then credit=0.
- m5 x3 (credit 15), then m1 -> reject=1, credit stays 15. A 4th m5 -> reject=1. Cancel -> change=15, change_valid=1, credit=0.
- credit=2, press i3 -> no vend, credit stays 2. Press i1 and i3 together -> item=1, change=1.
- m1 and m5 edges same cycle from IDLE -> credit=5, reject=1. Coin during VEND -> reject=1, credit unaffected.
- TIMEOUT=20, credit=1, no activity -> REFUND after 20 cycles, change=1. rst asserted during VEND -> all outputs 0 next edge, no change_valid.

Source files
------------

// File: rtl/vend_credit_ctrl.sv
// Credit accumulation and purchase FSM for the vending machine display path.
// Conditions raw coin/button levels, tracks credit and emits vend/change strobes.
module vend_credit_ctrl #(
    parameter int PRICE1     = 1,
    parameter int PRICE2     = 2,
    parameter int PRICE3     = 3,
    parameter int MAX_CREDIT = 15,
    parameter int CW         = 4,
    parameter int TIMEOUT    = 50000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m1,
    input  logic          m5,
    input  logic          i1,
    input  logic          i2,
    input  logic          i3,
    input  logic          cancel,
    output logic [CW-1:0] credit,
    output logic          vend,
    output logic [1:0]    item,
    output logic [CW-1:0] change,
    output logic          change_valid,
    output logic          reject,
    output logic          busy
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [CW-1:0] P1 = CW'(PRICE1);
    localparam logic [CW-1:0] P2 = CW'(PRICE2);
    localparam logic [CW-1:0] P3 = CW'(PRICE3);

    // Bit positions in the conditioned input vector.
    localparam int B_M1 = 0, B_M5 = 1, B_I1 = 2, B_I2 = 3, B_I3 = 4, B_CAN = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_VEND,
        S_CHANGE,
        S_REFUND
    } state_t;

    logic [5:0]    r_sync1, r_sync2, r_prev;
    state_t        r_state;
    logic [CW-1:0] r_credit;
    logic [1:0]    r_item;
    logic          r_reject;
    logic [TW-1:0] r_tcnt;

    logic [5:0]    w_raw, w_edge;
    state_t        w_state_nxt;
    logic [CW-1:0] w_credit_nxt;
    logic [1:0]    w_item_nxt;
    logic          w_reject_nxt;
    logic [TW-1:0] w_tcnt_nxt;

    logic          w_coin, w_m1_lost, w_coin_fits, w_timeout, w_afford;
    logic [CW:0]   w_coin_sum;
    logic [1:0]    w_sel_id;
    logic [CW-1:0] w_price;

    assign w_raw  = {cancel, i3, i2, i1, m5, m1};
    assign w_edge = r_sync2 & ~r_prev;

    assign w_coin      = w_edge[B_M1] | w_edge[B_M5];
    assign w_m1_lost   = w_edge[B_M1] & w_edge[B_M5];
    assign w_coin_sum  = {1'b0, r_credit} + (w_edge[B_M5] ? (CW+1)'(5) : (CW+1)'(1));
    assign w_coin_fits = w_coin_sum <= (CW+1)'(MAX_CREDIT);
    assign w_timeout   = r_tcnt == TW'(TIMEOUT - 1);
    assign w_afford    = r_credit >= w_price;

    always_comb begin
        w_sel_id = 2'd0;
        w_price  = '0;
        if (w_edge[B_I1]) begin
            w_sel_id = 2'd1;
            w_price  = P1;
        end else if (w_edge[B_I2]) begin
            w_sel_id = 2'd2;
            w_price  = P2;
        end else if (w_edge[B_I3]) begin
            w_sel_id = 2'd3;
            w_price  = P3;
        end
    end

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_item_nxt   = 2'd0;
        w_reject_nxt = 1'b0;
        w_tcnt_nxt   = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_coin && w_coin_fits) begin
                    w_credit_nxt = w_coin_sum[CW-1:0];
                    w_reject_nxt = w_m1_lost;
                    w_state_nxt  = S_COLLECT;
                end else begin
                    w_reject_nxt = w_coin;
                end
            end
            S_COLLECT: begin
                w_tcnt_nxt = r_tcnt + 1'b1;
                if (w_edge[B_CAN]) begin
                    w_reject_nxt = w_coin;
                    w_state_nxt  = S_REFUND;
                end else if (w_sel_id != 2'd0 && w_afford) begin
                    w_reject_nxt = w_coin;
                    w_credit_nxt = r_credit - w_price;
                    w_item_nxt   = w_sel_id;
                    w_state_nxt  = S_VEND;
                end else if (w_sel_id == 2'd0 && w_coin && w_coin_fits) begin
                    w_credit_nxt = w_coin_sum[CW-1:0];
                    w_reject_nxt = w_m1_lost;
                    w_tcnt_nxt   = '0;
                end else begin
                    // A select that cannot be afforded still claims the cycle, so the coin bounces.
                    w_reject_nxt = w_coin;
                    if (w_timeout) w_state_nxt = S_REFUND;
                end
                if (w_state_nxt != S_COLLECT) w_tcnt_nxt = '0;
            end
            S_VEND: begin
                w_reject_nxt = w_coin;
                w_state_nxt  = (r_credit != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE, S_REFUND: begin
                w_reject_nxt = w_coin;
                w_credit_nxt = '0;
                w_state_nxt  = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_state  <= S_IDLE;
            r_credit <= '0;
            r_item   <= 2'd0;
            r_reject <= 1'b0;
            r_tcnt   <= '0;
        end else begin
            r_sync1  <= w_raw;
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            r_item   <= w_item_nxt;
            r_reject <= w_reject_nxt;
            r_tcnt   <= w_tcnt_nxt;
        end
    end

    assign credit       = r_credit;
    assign vend         = (r_state == S_VEND);
    assign item         = r_item;
    assign change_valid = (r_state == S_CHANGE) || (r_state == S_REFUND);
    assign change       = change_valid ? r_credit : '0;
    assign reject       = r_reject;
    assign busy         = vend | change_valid;

endmodule
